region_frame_buffer: RTL

REGION_FRAME_BUFFER -- requirements
Module: region_frame_buffer

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_bank_ram.sv | 25 ++
 rtl/region_frame_buffer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared region constants, derived sizes and write FSM state type
package fb_pkg;

  localparam int FB_START_X = 390;
  localparam int FB_START_Y = 390;
  localparam int FB_END_X   = 634;
  localparam int FB_END_Y   = 765;
  localparam int FB_W       = FB_END_X - FB_START_X;
  localparam int FB_H       = FB_END_Y - FB_START_Y;
  localparam int FB_DEPTH   = 2 * FB_W * FB_H;

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } fb_state_t;

  // Offset bits needed to address one bank of the given pixel count.
  function automatic int fb_off_bits(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// rtl/fb_bank_ram.sv - simple dual-port RAM with two-cycle registered read
module fb_bank_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Write port plus read array stage and output register; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q  <= mem[raddr];
    rdata <= rd_q;
  end

endmodule

// File: rtl/region_frame_buffer.sv
// rtl/region_frame_buffer.sv - double-buffered pixel store for a rectangular display region
module region_frame_buffer
  import fb_pkg::*;
#(
  parameter int START_X     = FB_START_X,
  parameter int START_Y     = FB_START_Y,
  parameter int END_X       = FB_END_X,
  parameter int END_Y       = FB_END_Y,
  parameter int PIXEL_WIDTH = 12,
  parameter int X_SKEW      = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   wr_valid_in,
  output logic                   wr_ready_out,
  input  logic [10:0]            wr_hcount_in,
  input  logic [9:0]             wr_vcount_in,
  input  logic [PIXEL_WIDTH-1:0] wr_pixel_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   ad_in,
  input  logic                   nf_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   ad_out,
  output logic                   in_region_out,
  output logic                   front_bank_out,
  output logic [7:0]             swap_count_out,
  output logic [15:0]            drop_count_out
);

  localparam int W  = END_X - START_X;
  localparam int H  = END_Y - START_Y;
  localparam int OW = fb_off_bits(W * H);
  localparam int AW = OW + 1;
  // Bank bit is the address MSB, so each bank occupies a power-of-two slot.
  localparam int RAM_DEPTH = 1 << AW;

  fb_state_t state;

  // Write side: skewed coordinates, range check, bank offset.
  logic signed [13:0] wr_x;
  logic signed [12:0] wr_y;
  logic               wr_accept;
  logic               wr_in_range;
  logic               wr_en;
  logic               wr_last;
  logic [OW-1:0]      wr_off;

  assign wr_x        = $signed({3'b000, wr_hcount_in}) - 14'(START_X) - 14'(X_SKEW);
  assign wr_y        = $signed({3'b000, wr_vcount_in}) - 13'(START_Y);
  assign wr_accept   = wr_valid_in && wr_ready_out;
  assign wr_in_range = (wr_x >= 14'sd0) && (wr_x < 14'(W)) &&
                       (wr_y >= 13'sd0) && (wr_y < 13'(H));
  assign wr_en       = wr_accept && wr_in_range;
  assign wr_last     = wr_en && (wr_x == 14'(W - 1)) && (wr_y == 13'(H - 1));
  assign wr_off      = OW'(32'(wr_x) + 32'(wr_y) * W);

  // Read side: region test and front-bank address sampled at issue time.
  logic          rd_in_region;
  logic [OW-1:0] rd_off;
  logic [AW-1:0] rd_addr;

  assign rd_in_region = (hcount_in >= 11'(START_X)) && (hcount_in < 11'(END_X)) &&
                        (vcount_in >= 10'(START_Y)) && (vcount_in < 10'(END_Y));
  assign rd_off  = OW'((32'(hcount_in) - START_X) + (32'(vcount_in) - START_Y) * W);
  assign rd_addr = rd_in_region ? {front_bank_out, rd_off} : '0;

  logic [PIXEL_WIDTH-1:0] ram_rdata;

  fb_bank_ram #(
    .DATA_W (PIXEL_WIDTH),
    .ADDR_W (AW),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk   (clk_in),
    .we    (wr_en),
    .waddr ({~front_bank_out, wr_off}),
    .wdata (wr_pixel_in),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Write FSM: fill the back bank, then wait for a frame boundary to swap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= FILLING;
      wr_ready_out   <= 1'b1;
      front_bank_out <= 1'b0;
      swap_count_out <= 8'd0;
    end else begin
      case (state)
        FILLING: begin
          if (wr_last) begin
            state        <= FULL;
            wr_ready_out <= 1'b0;
          end
        end
        FULL: begin
          if (nf_in) begin
            state          <= FILLING;
            wr_ready_out   <= 1'b1;
            front_bank_out <= ~front_bank_out;
            swap_count_out <= swap_count_out + 8'd1;
          end
        end
        default: begin
          state        <= FILLING;
          wr_ready_out <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of accepted writes that fell outside the region.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_count_out <= 16'd0;
    end else if (wr_accept && !wr_in_range && (drop_count_out != 16'hFFFF)) begin
      drop_count_out <= drop_count_out + 16'd1;
    end
  end

  logic hs_d1, vs_d1, ad_d1, ir_d1;

  // Two-stage timing delay matching the RAM read latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      {hs_d1, vs_d1, ad_d1, ir_d1}           <= 4'b0000;
      {hs_out, vs_out, ad_out, in_region_out} <= 4'b0000;
    end else begin
      {hs_d1, vs_d1, ad_d1, ir_d1}           <= {hs_in, vs_in, ad_in, rd_in_region};
      {hs_out, vs_out, ad_out, in_region_out} <= {hs_d1, vs_d1, ad_d1, ir_d1};
    end
  end

  assign pixel_out = (in_region_out && ad_out) ? ram_rdata : '0;

endmodule
